// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: round-robin owner of the single vga_adapter write port.
// Three requesters (paddle, ball, brick) each describe a rectangle. The granted
// rectangle is walked row-major, one pixel per clock. Pixels off the visible
// screen are not plotted but still take their cycle.
module vga_draw_scheduler #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int WBITS   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         req,
  input  logic [23:0]        rect_x,
  input  logic [20:0]        rect_y,
  input  logic [3*WBITS-1:0] rect_w,
  input  logic [3*WBITS-1:0] rect_h,
  input  logic [8:0]         rect_colour,
  output logic [2:0]         grant,
  output logic [2:0]         done,
  output logic               busy,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               plot
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  localparam logic [WBITS-1:0] ONE = 1;

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       win_q, win_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       x0_q, x0_d;
  logic [6:0]       y0_q, y0_d;
  logic [WBITS-1:0] w_q, w_d, h_q, h_d, xc_q, xc_d, yc_q, yc_d;
  logic [2:0]       col_q, col_d;
  logic [7:0]       last_x_q, last_x_d;
  logic [6:0]       last_y_q, last_y_d;
  logic [2:0]       last_col_q, last_col_d;

  // Per-requester views of the packed rectangle fields.
  logic [7:0]       rx [3];
  logic [6:0]       ry [3];
  logic [WBITS-1:0] rw [3];
  logic [WBITS-1:0] rh [3];
  logic [2:0]       rc [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_fields
    assign rx[gi] = rect_x[8*gi +: 8];
    assign ry[gi] = rect_y[7*gi +: 7];
    assign rw[gi] = rect_w[WBITS*gi +: WBITS];
    assign rh[gi] = rect_h[WBITS*gi +: WBITS];
    assign rc[gi] = rect_colour[3*gi +: 3];
  end

  // Pixel address is formed one bit wider so wrapped coordinates fail the bounds test.
  logic [8:0] px_sum;
  logic [7:0] py_sum;
  logic       in_bounds, x_last, y_last;

  assign px_sum    = {1'b0, x0_q} + {{(9-WBITS){1'b0}}, xc_q};
  assign py_sum    = {1'b0, y0_q} + {{(8-WBITS){1'b0}}, yc_q};
  assign in_bounds = (px_sum < 9'(XSCREEN)) && (py_sum < 8'(YSCREEN));
  assign x_last    = (xc_q == w_q - ONE);
  assign y_last    = (yc_q == h_q - ONE);

  // Round-robin pick: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
  logic [1:0] cand [3];
  logic       found;
  logic [1:0] win;
  always_comb begin
    cand[0] = ptr_q;
    cand[1] = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    cand[2] = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
    found   = 1'b0;
    win     = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[cand[i]]) begin
        found = 1'b1;
        win   = cand[i];
      end
    end
  end

  // State and datapath registers; reset aborts any rectangle in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      win_q      <= '0;
      ptr_q      <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      xc_q       <= '0;
      yc_q       <= '0;
      col_q      <= '0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      last_col_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      xc_q       <= xc_d;
      yc_q       <= yc_d;
      col_q      <= col_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      last_col_q <= last_col_d;
    end
  end

  // Next state: empty rectangles skip DRAW and report completion at once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = (rw[win] == '0 || rh[win] == '0) ? S_DONE : S_DRAW;
        end
      end
      S_DRAW: begin
        if (x_last && y_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates and port outputs.
  always_comb begin
    grant_d    = grant_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    xc_d       = xc_q;
    yc_d       = yc_q;
    col_d      = col_q;
    last_x_d   = last_x_q;
    last_y_d   = last_y_q;
    last_col_d = last_col_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = 3'b001 << win;
          win_d   = win;
          x0_d    = rx[win];
          y0_d    = ry[win];
          w_d     = rw[win];
          h_d     = rh[win];
          col_d   = rc[win];
          xc_d    = '0;
          yc_d    = '0;
        end
      end
      S_DRAW: begin
        last_x_d   = px_sum[7:0];
        last_y_d   = py_sum[6:0];
        last_col_d = col_q;
        if (x_last) begin
          xc_d = '0;
          yc_d = yc_q + ONE;
        end else begin
          xc_d = xc_q + ONE;
        end
      end
      S_DONE: begin
        grant_d = '0;
        ptr_d   = (win_q == 2'd2) ? 2'd0 : win_q + 2'd1;
      end
      default: ;
    endcase

    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE) ? grant_q : 3'b000;
    plot       = (state_q == S_DRAW) && in_bounds;
    vga_x      = (state_q == S_DRAW) ? px_sum[7:0] : last_x_q;
    vga_y      = (state_q == S_DRAW) ? py_sum[6:0] : last_y_q;
    vga_colour = (state_q == S_DRAW) ? col_q : last_col_q;
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// Directed bench for vga_draw_scheduler: expected pixels are queued per
// rectangle as it is requested and matched against every plotted pixel.
module tb_vga_draw_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] rect_x = '0;
  logic [20:0] rect_y = '0;
  logic [14:0] rect_w = '0;
  logic [14:0] rect_h = '0;
  logic [8:0]  rect_colour = '0;
  logic [2:0]  grant, done, vga_colour;
  logic        busy, plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;

  int n_cmp = 0;
  int n_fail = 0;
  logic [17:0] exp_q [$];

  vga_draw_scheduler #(.XSCREEN(160), .YSCREEN(120), .WBITS(5)) dut (
    .clock(clock), .reset(reset), .req(req),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_colour(rect_colour), .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic set_rect(input int idx, input int x, input int y, input int w,
                          input int h, input int c);
    rect_x[8*idx +: 8]      = 8'(x);
    rect_y[7*idx +: 7]      = 7'(y);
    rect_w[5*idx +: 5]      = 5'(w);
    rect_h[5*idx +: 5]      = 5'(h);
    rect_colour[3*idx +: 3] = 3'(c);
  endtask

  // Reference model: row-major walk, clipped to the 160x120 screen.
  task automatic push_rect(input int x, input int y, input int w, input int h, input int c);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        if (x + xx < 160 && y + yy < 120) begin
          exp_q.push_back({8'(x + xx), 7'(y + yy), 3'(c)});
        end
      end
    end
  endtask

  // Waits for a done pulse; exp_cycles counts negedges from the call to the pulse.
  task automatic wait_done(input string tag, input logic [2:0] exp_g, input int exp_cycles);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (done == 3'b000 && cyc < 300);
    check({tag, "_done"}, 32'(done), 32'(exp_g));
    check({tag, "_grant"}, 32'(grant), 32'(exp_g));
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
    $display("txn %s: done=%b after %0d cycles", tag, done, cyc);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant0"}, 32'(grant), 32'd0);
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Pixel scoreboard and single-owner check every cycle.
  always @(negedge clock) begin
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    if (plot) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", {14'd0, vga_x, vga_y, vga_colour}, 32'hFFFF_FFFF);
      end else begin
        check("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int np, cyc;
    // Reset held with all requests active.
    reset = 1'b1;
    req   = 3'b111;
    set_rect(0, 10, 10, 2, 2, 1);
    set_rect(1, 20, 20, 2, 2, 2);
    set_rect(2, 30, 30, 2, 2, 4);
    repeat (3) begin
      @(negedge clock);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_plot", 32'(plot), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end

    // Round robin, all requests held: 001, 010, 100, 001.
    push_rect(10, 10, 2, 2, 1);
    push_rect(20, 20, 2, 2, 2);
    push_rect(30, 30, 2, 2, 4);
    push_rect(10, 10, 2, 2, 1);
    reset = 1'b0;
    wait_done("rr0", 3'b001, 5);
    wait_done("rr1", 3'b010, 6);
    wait_done("rr2", 3'b100, 6);
    wait_done("rr3", 3'b001, 6);
    req = 3'b000;
    check_idle("rr_end");

    // Single paddle 20x1 line.
    set_rect(0, 39, 100, 20, 1, 7);
    push_rect(39, 100, 20, 1, 7);
    req = 3'b001;
    wait_done("paddle", 3'b001, 21);
    req = 3'b000;
    check_idle("paddle_end");

    // Clipping at the bottom-right corner: 12 cycles, 4 pixels.
    set_rect(2, 158, 118, 4, 3, 5);
    push_rect(158, 118, 4, 3, 5);
    check("clip_model_pixels", 32'(exp_q.size()), 32'd4);
    req = 3'b100;
    wait_done("clip", 3'b100, 13);
    req = 3'b000;
    check_idle("clip_end");

    // Zero-width ball: done right after grant, no pixels.
    set_rect(1, 50, 50, 0, 5, 2);
    req = 3'b010;
    wait_done("zero", 3'b010, 1);
    req = 3'b000;
    check_idle("zero_end");

    // Normal request after the empty one.
    set_rect(0, 10, 20, 3, 2, 3);
    push_rect(10, 20, 3, 2, 3);
    req = 3'b001;
    wait_done("after_zero", 3'b001, 7);
    req = 3'b000;
    check_idle("after_zero_end");

    // Reset at the 7th pixel of a 20x1 draw.
    set_rect(0, 0, 0, 20, 1, 6);
    push_rect(0, 0, 20, 1, 6);
    req = 3'b001;
    np = 0;
    cyc = 0;
    while (np < 7 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (plot) np++;
    end
    check("abort_pixels_seen", 32'(np), 32'd7);
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clock);
    check("abort_plot", 32'(plot), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_grant", 32'(grant), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_left", 32'(exp_q.size()), 32'd13);
    $display("txn abort: reset after %0d pixels", np);
    exp_q.delete();
    reset = 1'b0;

    // Pointer back at 0: paddle wins even though ball and brick also ask.
    set_rect(0, 10, 10, 2, 2, 1);
    set_rect(1, 20, 20, 2, 2, 2);
    set_rect(2, 30, 30, 2, 2, 4);
    push_rect(10, 10, 2, 2, 1);
    req = 3'b111;
    wait_done("ptr_reset", 3'b001, 5);
    req = 3'b000;
    check_idle("ptr_reset_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
- Shares the single `vga_adapter` pixel-write port (x, y, colour, plot) between three rectangle-drawing requesters: paddle draw/erase, ball draw/erase and brick draw/erase.
- Grants one requester at a time, round-robin, and walks its rectangle one pixel per clock, row-major.
- Pulses `done` back to the winning requester when the rectangle is finished.
- Replaces the ad-hoc per-object draw/erase FSMs and their shared x/y counters in the top level.

Parameters:
- XSCREEN, 160, screen width in pixels; pixels with x >= XSCREEN are not plotted.
- YSCREEN, 120, screen height in pixels; pixels with y >= YSCREEN are not plotted.
- WBITS, 5, width of each rectangle width/height field (max 31).

Ports:
- clock  in  1  system clock (`CLOCK_50` domain).
- reset  in  1  synchronous, active-high reset.
- req  in  3  request per requester; bit 0 = paddle, 1 = ball, 2 = brick.
- rect_x  in  24  packed 3x8 top-left x; requester i uses bits [8i+7:8i].
- rect_y  in  21  packed 3x7 top-left y; requester i uses bits [7i+6:7i].
- rect_w  in  3*WBITS  packed rectangle widths.
- rect_h  in  3*WBITS  packed rectangle heights.
- rect_colour  in  9  packed 3x3 colour; use 3'b000 to erase.
- grant  out  3  one-hot; the current owner, held for the whole transaction.
- done  out  3  one-cycle pulse on the owner's bit when its rectangle is complete.
- busy  out  1  high whenever the state is not IDLE.
- vga_x  out  8  pixel x to `vga_adapter`.
- vga_y  out  7  pixel y to `vga_adapter`.
- vga_colour  out  3  pixel colour to `vga_adapter`.
- plot  out  1  pixel write strobe to `vga_adapter`.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; grant = 0; done = 0; plot = 0; vga_x = 0; vga_y = 0; vga_colour = 0; busy = 0; round-robin pointer = 0; x/y counters = 0.
  - Reset asserted mid-DRAW aborts the rectangle.
  - No `done` pulse is issued for the aborted rectangle.
  - `plot` is 0 from the cycle after the reset edge.
- States: IDLE, DRAW, DONE.
- IDLE:
  - If req != 0 at a clock edge, select the first set bit scanning from the pointer upward with wrap (pointer, pointer+1, pointer+2, all mod 3).
  - At that edge: set grant to the winner, latch its x/y/w/h/colour into internal registers, clear xc and yc, go to DRAW.
  - If the latched w == 0 or h == 0, go directly to DONE instead; no pixels are plotted.
- DRAW:
  - vga_x = x0 + xc (8-bit, wraps); vga_y = y0 + yc (7-bit, wraps); vga_colour = latched colour.
  - plot = 1 only when (x0 + xc) < XSCREEN and (y0 + yc) < YSCREEN.
  - The bounds check is computed at 9/8 bits, so wrapped coordinates are never plotted.
  - Out-of-bounds pixels still consume their cycle.
  - Each cycle: xc increments. When xc == w-1, xc clears and yc increments. When xc == w-1 and yc == h-1, go to DONE.
  - Exactly w*h DRAW cycles.
- DONE:
  - `done` pulses on the grant bit for one cycle; grant stays asserted this cycle; plot = 0.
  - Next edge: go to IDLE, grant = 0, pointer = (winner+1) mod 3.
- Latency:
  - The req edge that wins arbitration is edge k.
  - First pixel is presented in the cycle after edge k; last pixel in cycle k + w*h.
  - `done` is high in cycle k + w*h + 1.
  - The earliest next grant is at edge k + w*h + 2 (IDLE is always visited for at least one cycle).
- Handshake:
  - A requester holds req and its rect fields until it sees its done bit.
  - Inputs are sampled only at the grant edge; changes during DRAW are ignored.
  - A req deasserted mid-transaction does not abort it.
  - A req still high in the DONE cycle is treated as a new request in the following IDLE.
- Simultaneous requests: only one grant at a time; rotation guarantees each active requester is served within 2 other transactions.
- Outside DRAW, vga_x/vga_y/vga_colour hold their last values; only plot is required to be 0.

Test Plan:
- Reset held 3 cycles, req=3'b111 -> grant=0, plot=0, busy=0 throughout; after release, first grant=3'b001.
- Single paddle request (x=39, y=100, w=20, h=1, colour=3'b111):
  - Exactly 20 plot cycles, x = 39..58, y = 100, colour 7.
  - done=3'b001 for 1 cycle, then busy=0.
- req=3'b111 held continuously, each rect 2x2:
  - Grant order 001, 010, 100, 001.
  - Each owner gets 4 plot cycles; no overlap between grants.
- Clipping (x=158, y=118, w=4, h=3):
  - 12 DRAW cycles; plot high only for x in {158, 159} with y in {118, 119}, i.e. 4 pixels.
  - done still pulses.
- Zero-size rectangle (w=0, h=5) on ball:
  - No plot cycles; done=3'b010 one cycle after grant; next request is served normally.
- Reset asserted at the 7th pixel of a 20x1 draw -> plot=0 next cycle, no done pulse, grant=0, pointer returns to 0.
